// File: rtl/gptp_tx_arb.sv
// Round-robin, packet-locked arbiter that merges N requester beat streams onto
// a single TX channel through one output register stage.
module gptp_tx_arb #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*DW-1:0]      req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int GW = $clog2(N);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Reset value of last_grant makes requester 0 the first one searched.
    localparam logic [GW-1:0] LAST_GRANT_RST = GW'(N - 1);

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic          rr_found;
    logic [GW-1:0] rr_winner;
    logic [GW-1:0] rr_idx;

    logic          locked;
    logic          can_load;
    logic          g_valid;
    logic          g_last;
    logic [DW-1:0] g_data;
    logic          accept;

    // Round-robin search: start one past the previous winner and wrap.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
        rr_found  = 1'b0;
        rr_winner = last_grant_q;
        rr_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = GW'((int'(last_grant_q) + k) % N);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    assign locked   = (state_q == ST_LOCK);
    assign can_load = !out_valid_q || out_ready;
    assign g_valid  = req_valid[grant_q];
    assign g_last   = req_last[grant_q];
    assign g_data   = req_data[int'(grant_q)*DW +: DW];
    assign accept   = locked && g_valid && can_load;

    always_comb begin
        req_ready = '0;
        if (locked) begin
            req_ready[grant_q] = can_load;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_winner;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept && g_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The final beat of a packet keeps draining here after the FSM unlocks.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = g_data;
            out_last_d  = g_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant_id  = grant_q;
    assign busy      = locked;

endmodule

// File: tb/tb_gptp_tx_arb.sv
// Self-checking bench for gptp_tx_arb: per-requester beat queues drive the
// inputs, a scoreboard checks every beat leaving the output register.
module tb_gptp_tx_arb;

    localparam int NR = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [NR-1:0] mask;
        int            exp_grant;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             out_ready;
    logic [1:0]       grant_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    beat_t         src[NR][$];
    beat_t         exp_q[$];
    logic [NR-1:0] hs_s;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    vec_t          vecs[13];

    gptp_tx_arb #(.N(NR), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NR; i++) begin
            if (src[i].size() > 0) begin
                req_valid[i]            = 1'b1;
                req_data[i*DW +: DW]    = src[i][0].data;
                req_last[i]             = src[i][0].last;
            end else begin
                req_valid[i]            = 1'b0;
                req_data[i*DW +: DW]    = '0;
                req_last[i]             = 1'b0;
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) src[i].delete();
    endtask

    // One clock: retire beats accepted at this edge, present the next ones.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs_s[i] && src[i].size() > 0) void'(src[i].pop_front());
        end
        refresh();
        #1;
    endtask

    task automatic push(input int r, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src[r].push_back(b);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clear_src();
        refresh();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: protocol rules and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        beat_t e;
        if (!rst_n) begin
            exp_q.delete();
            hs_s       = '0;
            prev_stall = 1'b0;
        end else begin
            exp_rdy = '0;
            if (busy && (!out_valid || out_ready)) exp_rdy[grant_id] = 1'b1;
            check("ready_rule", 64'(req_ready), 64'(exp_rdy));
            if (prev_stall) begin
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_last", 64'(out_last), 64'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got beat %0h with nothing expected at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 64'(out_data), 64'(e.data));
                    check("sb_last", 64'(out_last), 64'(e.last));
                end
            end
            hs_s = req_valid & req_ready;
            for (int i = 0; i < NR; i++) begin
                if (hs_s[i]) begin
                    e.data = req_data[i*DW +: DW];
                    e.last = req_last[i];
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        hs_s       = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;

        vecs[0]  = '{4'b1111, 0};
        vecs[1]  = '{4'b1111, 1};
        vecs[2]  = '{4'b1111, 2};
        vecs[3]  = '{4'b1111, 3};
        vecs[4]  = '{4'b1111, 0};
        vecs[5]  = '{4'b0100, 2};
        vecs[6]  = '{4'b0101, 0};
        vecs[7]  = '{4'b1001, 3};
        vecs[8]  = '{4'b1001, 0};
        vecs[9]  = '{4'b0010, 1};
        vecs[10] = '{4'b1100, 2};
        vecs[11] = '{4'b1011, 3};
        vecs[12] = '{4'b0011, 0};

        // Single-beat packets: grant order and one arbitration cycle per packet.
        do_reset();
        for (int r = 0; r < 13; r++) begin
            clear_src();
            for (int i = 0; i < NR; i++) begin
                if (vecs[r].mask[i]) push(i, 32'h1000_0000 | (r << 8) | i, 1'b1);
            end
            refresh();
            tick();
            check("tbl_grant", 64'(grant_id), 64'(vecs[r].exp_grant));
            check("tbl_busy_arb", 64'(busy), 64'(1));
            check("tbl_ready", 64'(req_ready), 64'(1 << vecs[r].exp_grant));
            tick();
            check("tbl_busy_done", 64'(busy), 64'(0));
            check("tbl_out_valid", 64'(out_valid), 64'(1));
            check("tbl_out_data", 64'(out_data), 64'(32'h1000_0000 | (r << 8) | vecs[r].exp_grant));
            check("tbl_out_last", 64'(out_last), 64'(1));
        end
        clear_src();
        refresh();
        tick();
        check("tbl_drain", 64'(out_valid), 64'(0));

        // Three-beat packet from requester 0.
        do_reset();
        push(0, 32'hAAAA_0001, 1'b0);
        push(0, 32'hBBBB_0002, 1'b0);
        push(0, 32'hCCCC_0003, 1'b1);
        refresh();
        tick();
        check("p3_grant", 64'(grant_id), 64'(0));
        check("p3_busy", 64'(busy), 64'(1));
        check("p3_nobeat_idle", 64'(out_valid), 64'(0));
        tick();
        check("p3_a", 64'(out_data), 64'(32'hAAAA_0001));
        check("p3_a_last", 64'(out_last), 64'(0));
        tick();
        check("p3_b", 64'(out_data), 64'(32'hBBBB_0002));
        tick();
        check("p3_c", 64'(out_data), 64'(32'hCCCC_0003));
        check("p3_c_last", 64'(out_last), 64'(1));
        check("p3_unlock", 64'(busy), 64'(0));
        tick();
        check("p3_drained", 64'(out_valid), 64'(0));

        // Downstream stall for five cycles mid-packet.
        do_reset();
        push(0, 32'hD000_0000, 1'b0);
        push(0, 32'hD000_0001, 1'b0);
        push(0, 32'hD000_0002, 1'b1);
        refresh();
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        check("stall_ready", 64'(req_ready), 64'(0));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_data", 64'(out_data), 64'(32'hD000_0000));
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_busy", 64'(busy), 64'(1));
        end
        out_ready = 1'b1;
        #1;
        check("unstall_ready", 64'(req_ready), 64'(1));
        tick();
        check("stall_d1", 64'(out_data), 64'(32'hD000_0001));
        tick();
        check("stall_d2", 64'(out_data), 64'(32'hD000_0002));
        check("stall_d2_last", 64'(out_last), 64'(1));
        tick();

        // No re-arbitration mid-packet.
        do_reset();
        for (int b = 0; b < 4; b++) push(2, 32'h2200_0000 | b, b == 3);
        refresh();
        tick();
        check("lock_grant2", 64'(grant_id), 64'(2));
        tick();
        push(1, 32'h1100_0000, 1'b1);
        refresh();
        #1;
        check("lock_ready_only2", 64'(req_ready), 64'(4'b0100));
        tick();
        check("lock_hold_grant", 64'(grant_id), 64'(2));
        check("lock_ready_b2", 64'(req_ready), 64'(4'b0100));
        tick();
        tick();
        check("lock_last_out", 64'(out_data), 64'(32'h2200_0003));
        check("lock_released", 64'(busy), 64'(0));
        check("lock_grant_kept", 64'(grant_id), 64'(2));
        tick();
        check("lock_next_grant", 64'(grant_id), 64'(1));
        check("lock_next_busy", 64'(busy), 64'(1));
        tick();
        check("lock_q_out", 64'(out_data), 64'(32'h1100_0000));
        tick();

        // Reset asserted while beat 2 of a requester-3 packet is in flight.
        do_reset();
        for (int b = 0; b < 4; b++) push(3, 32'h3300_0000 | b, b == 3);
        refresh();
        tick();
        check("mr_grant3", 64'(grant_id), 64'(3));
        tick();
        tick();
        check("mr_beat2", 64'(out_data), 64'(32'h3300_0001));
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'(0));
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_grant0", 64'(grant_id), 64'(0));
        clear_src();
        refresh();
        tick();
        rst_n = 1'b1;
        push(1, 32'h5100_0000, 1'b1);
        push(3, 32'h5300_0000, 1'b1);
        refresh();
        tick();
        check("mr_req1_wins", 64'(grant_id), 64'(1));
        tick();
        check("mr_req1_out", 64'(out_data), 64'(32'h5100_0000));
        tick();
        check("mr_req3_next", 64'(grant_id), 64'(3));
        tick();
        check("mr_req3_out", 64'(out_data), 64'(32'h5300_0000));
        tick();

        // Requester 1 finishes while requesters 1 and 2 both have traffic.
        do_reset();
        push(1, 32'h6100_0000, 1'b0);
        push(1, 32'h6100_0001, 1'b1);
        push(1, 32'h6100_0002, 1'b1);
        push(2, 32'h6200_0000, 1'b1);
        refresh();
        tick();
        check("rr_first1", 64'(grant_id), 64'(1));
        tick();
        tick();
        check("rr_t1_last", 64'(out_last), 64'(1));
        check("rr_t1_idle", 64'(busy), 64'(0));
        tick();
        check("rr_next2", 64'(grant_id), 64'(2));
        tick();
        check("rr_u0", 64'(out_data), 64'(32'h6200_0000));
        tick();
        check("rr_back1", 64'(grant_id), 64'(1));
        tick();
        check("rr_t2", 64'(out_data), 64'(32'h6100_0002));
        tick();
        tick();
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gptp_tx_arb.md
GPTP_TX_ARB -- requirements
Module: gptp_tx_arb

Interface
REQ-001 SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 32, giving the data beat width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, N bits: per-requester beat valid.
REQ-006 SHALL have port req_data, input, N*DW bits: requester i drives bits [i*DW +: DW].
REQ-007 SHALL have port req_last, input, N bits: per-requester last beat of a packet.
REQ-008 SHALL have port req_ready, output, N bits: per-requester beat accepted.
REQ-009 SHALL have port out_valid, output, 1 bit: shared TX beat valid.
REQ-010 SHALL have port out_data, output, DW bits: shared TX beat data.
REQ-011 SHALL have port out_last, output, 1 bit: shared TX last beat.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-013 SHALL have port grant_id, output, $clog2(N) bits: index of the locked requester.
REQ-014 SHALL have port busy, output, 1 bit: high while in LOCK.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and LOCK.
REQ-016 In IDLE with any req_valid high, SHALL pick a winner by round-robin: search starts at last_grant+1 and wraps N-1 -> 0; the first requester with valid high wins.
REQ-017 SHALL register the winner into grant_id and enter LOCK on the same edge; arbitration costs exactly one cycle, and no beat is accepted in IDLE.
REQ-018 In IDLE with no req_valid high, SHALL remain in IDLE with grant_id unchanged.
REQ-019 In LOCK, req_ready[grant_id] SHALL equal (!out_valid || out_ready); all other req_ready bits SHALL be 0; all req_ready bits SHALL be 0 in IDLE.
REQ-020 SHALL use a single output register stage: on req_valid[g] && req_ready[g], load out_data, out_last and out_valid=1 on the next edge (latency 1 cycle).
REQ-021 SHALL clear out_valid when out_ready is high and no new beat loads on that edge.
REQ-022 While out_valid && !out_ready, SHALL hold out_data and out_last stable.
REQ-023 On acceptance of a beat with req_last[g]=1, SHALL set last_grant=g and return to IDLE on that edge; the packet's final beat still drains from the output register.
REQ-024 SHALL NOT re-arbitrate mid-packet: other requesters' valids are ignored until the locked requester's last beat is accepted.
REQ-025 A packet of length 1 (valid and last together) SHALL be legal; LOCK then lasts exactly one accepting cycle.
REQ-026 SHALL ignore req_data and req_last of non-granted requesters.
REQ-027 If the locked requester drops req_valid mid-packet, SHALL stay in LOCK indefinitely; no timeout is applied.
REQ-028 busy SHALL be 1 exactly when the FSM is in LOCK.

Reset
REQ-029 While rst_n=0, SHALL force state=IDLE, out_valid=0, out_data=0, out_last=0, grant_id=0, busy=0, and last_grant=N-1, so requester 0 has first priority.
REQ-030 Reset asserted mid-packet SHALL discard the in-flight beat immediately; after release, arbitration restarts from requester 0.

Verification
REQ-031 Scenario: only req 0 sends 3 beats A,B,C, last on C, out_ready=1 -> grant_id=0 and busy=1 at edge 1; out_data A,B,C on cycles 2-4 with out_last on C; busy=0 after C is accepted.
REQ-032 Scenario: all four requesters hold continuous 1-beat packets -> grant order 0,1,2,3,0 with one idle arbitration cycle between packets.
REQ-033 Scenario: out_ready=0 for 5 cycles mid-packet -> out_data and out_last held, req_ready all 0, no beat lost or duplicated once out_ready=1.
REQ-034 Scenario: req 2 is locked on a 4-beat packet and req 1 raises valid at beat 2 -> req 1 is granted only in the arbitration cycle after req 2's last beat is accepted.
REQ-035 Scenario: rst_n pulsed low during beat 2 of a req 3 packet -> out_valid=0, busy=0 and grant_id=0 immediately; on the next request from reqs 1 and 3, req 1 wins.
REQ-036 Scenario: req 1 issues its last beat while reqs 1 and 2 both hold valid -> next grant is req 2, not req 1.
